spi_slave_mem_if: RTL and testbench

- SPI slave endpoint inside TOP; the counterpart of the Master_Top SPI master.
- Deserialises the 16-bit address word and the data words that follow it.
- Write frames (addr[15]=1): issues memory-bus write strobes to CNN weight, filter and image storage.
- Read frames (addr[15]=0): fetches words from the bus and shifts them out on MISO.
- SPI mode 0, MSB first. All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_slave_mem_if.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_mem_if.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem_if.sv
// SPI mode-0 slave that turns framed SPI transfers into memory-bus write/read strobes.
// Optional macro SPI_SLV_TRISTATE_EN floats MISO while the slave is deselected.
module spi_slave_mem_if #(
  parameter int                DWIDTH      = 16,
  parameter int                AWIDTH      = 15,
  parameter logic [DWIDTH-1:0] SIG         = 16'hA5C3,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              nSS,
  output logic              MISO,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              frame_done,
  output logic [15:0]       word_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r, mosi_sync_r, nss_sync_r;
  logic                   sck_prev_r, nss_prev_r;
  logic                   sck_s, mosi_s, nss_s;
  logic                   sck_rise_s, sck_fall_s, nss_rise_s, nss_fall_s, last_bit_s;
  logic [DWIDTH-1:0]      rx_next_s;
  logic [15:0]            wc_inc_s;

  state_t                 state_r;
  logic [DWIDTH-1:0]      rx_r, tx_r;
  logic [3:0]             bit_cnt_r;
  logic [AWIDTH-1:0]      base_r;
  logic                   wr_mode_r, ld_pend_r, miso_r;

  // Synchronise the SPI inputs and keep one extra sample for edge detection
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sck_sync_r  <= '0;
      mosi_sync_r <= '0;
      nss_sync_r  <= '0;
      sck_prev_r  <= 1'b0;
      nss_prev_r  <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      nss_sync_r  <= {nss_sync_r[SYNC_STAGES-2:0], nSS};
      sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
      nss_prev_r  <= nss_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign nss_s      = nss_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_r;
  assign sck_fall_s = ~sck_s & sck_prev_r;
  assign nss_rise_s = nss_s & ~nss_prev_r;
  assign nss_fall_s = ~nss_s & nss_prev_r;
  assign rx_next_s  = {rx_r[DWIDTH-2:0], mosi_s};
  assign last_bit_s = sck_rise_s && (bit_cnt_r == 4'd15);
  assign wc_inc_s   = (word_cnt == 16'hFFFF) ? 16'hFFFF : word_cnt + 16'd1;

`ifdef SPI_SLV_TRISTATE_EN
  assign MISO = nss_s ? 1'bz : miso_r;
`else
  assign MISO = miso_r;
`endif

  // Frame sequencer: shifting, word assembly and bus strobes
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r    <= IDLE;
      rx_r       <= '0;
      tx_r       <= '0;
      bit_cnt_r  <= 4'd0;
      base_r     <= '0;
      wr_mode_r  <= 1'b0;
      ld_pend_r  <= 1'b0;
      miso_r     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
      word_cnt   <= 16'd0;
    end else begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
      ld_pend_r  <= mem_re;

      if (state_r != IDLE) begin
        if (sck_rise_s) begin
          rx_r      <= rx_next_s;
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
        if (sck_fall_s) begin
          miso_r <= tx_r[DWIDTH-1];
          tx_r   <= {tx_r[DWIDTH-2:0], 1'b0};
        end
      end

      case (state_r)
        IDLE: begin
          if (nss_fall_s) begin
            // First signature bit goes straight onto MISO, the rest waits in tx
            state_r   <= ADDR;
            miso_r    <= SIG[DWIDTH-1];
            tx_r      <= {SIG[DWIDTH-2:0], 1'b0};
            rx_r      <= '0;
            bit_cnt_r <= 4'd0;
            word_cnt  <= 16'd0;
          end
        end
        ADDR: begin
          if (nss_rise_s) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            miso_r    <= 1'b0;
          end else if (last_bit_s) begin
            state_r   <= DATA;
            base_r    <= rx_next_s[AWIDTH-1:0];
            wr_mode_r <= rx_next_s[DWIDTH-1];
            if (rx_next_s[DWIDTH-1]) begin
              tx_r <= '0;
            end else begin
              mem_re   <= 1'b1;
              mem_addr <= rx_next_s[AWIDTH-1:0];
            end
          end
        end
        DATA: begin
          if (nss_rise_s) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            miso_r     <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            if (ld_pend_r) begin
              tx_r <= mem_rdata;
            end
            if (last_bit_s) begin
              word_cnt <= wc_inc_s;
              if (wr_mode_r) begin
                mem_we    <= 1'b1;
                mem_wdata <= rx_next_s;
                mem_addr  <= base_r + word_cnt[AWIDTH-1:0];
              end else begin
                mem_re   <= 1'b1;
                mem_addr <= base_r + wc_inc_s[AWIDTH-1:0];
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_mem_if.sv
// Directed plus randomised frames against spi_slave_mem_if, checked against a frame-level model.
module tb_spi_slave_mem_if;

  localparam int          HALF  = 5;
  localparam logic [15:0] SIG_W = 16'hA5C3;

  logic        clk = 1'b0;
  logic        nRst, SCK, MOSI, nSS, MISO;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, word_cnt;
  logic        mem_we, mem_re, frame_done;

  always #5 clk = ~clk;

  spi_slave_mem_if dut (
    .clk(clk), .nRst(nRst), .SCK(SCK), .MOSI(MOSI), .nSS(nSS), .MISO(MISO),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .frame_done(frame_done), .word_cnt(word_cnt)
  );

  typedef struct packed {logic [14:0] a; logic [15:0] d;} wr_t;

  logic [15:0] mem [0:32767];
  wr_t         wr_log[$];
  logic [14:0] rd_log[$];
  int          fdone_cnt = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  logic [15:0] tx_words [8];
  logic [15:0] rx_words [8];
  logic [15:0] rx_addr;

  // Bus model and strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (mem_re) begin
      rd_log.push_back(mem_addr);
      mem_rdata = mem[mem_addr];
    end
    if (frame_done) fdone_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    fdone_cnt = 0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    MOSI = b;
    repeat (HALF) @(negedge clk);
    m = MISO;
    SCK = 1'b1;
    repeat (HALF) @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic spi_word(input logic [15:0] w, input int nbits, output logic [15:0] r);
    logic m;
    r = 16'h0000;
    for (int i = 15; i > 15 - nbits; i--) begin
      spi_bit(w[i], m);
      r[i] = m;
    end
  endtask

  task automatic do_frame(input logic [15:0] addr, input int addr_bits, input int nwords,
                          input int last_bits);
    logic [15:0] r;
    nSS = 1'b0;
    repeat (2*HALF) @(negedge clk);
    spi_word(addr, addr_bits, rx_addr);
    for (int k = 0; k < nwords; k++) begin
      spi_word(tx_words[k], (k == nwords - 1) ? last_bits : 16, r);
      rx_words[k] = r;
    end
    repeat (HALF) @(negedge clk);
    nSS = 1'b1;
    repeat (4*HALF) @(negedge clk);
  endtask

  function automatic logic [31:0] bus_addr(input logic [15:0] base, input int k);
    return 32'((int'(base[14:0]) + k) % 32768);
  endfunction

  task automatic check_deselect(input string tag);
`ifdef SPI_SLV_TRISTATE_EN
    check({tag, "_miso_idle"}, 32'(MISO), 32'(1'bz));
`else
    check({tag, "_miso_idle"}, 32'(MISO), 32'd0);
`endif
  endtask

  task automatic check_write(input string tag, input logic [15:0] addr, input int n);
    check({tag, "_sig"}, 32'(rx_addr), 32'(SIG_W));
    check({tag, "_we_count"}, wr_log.size(), n);
    for (int k = 0; k < n && k < wr_log.size(); k++) begin
      check({tag, "_we_addr"}, 32'(wr_log[k].a), bus_addr(addr, k));
      check({tag, "_we_data"}, 32'(wr_log[k].d), 32'(tx_words[k]));
    end
    check({tag, "_re_count"}, rd_log.size(), 0);
    check({tag, "_word_cnt"}, 32'(word_cnt), n);
    check({tag, "_frame_done"}, fdone_cnt, 1);
    check_deselect(tag);
  endtask

  task automatic check_read(input string tag, input logic [15:0] addr, input int n);
    check({tag, "_sig"}, 32'(rx_addr), 32'(SIG_W));
    check({tag, "_re_count"}, rd_log.size(), n + 1);
    for (int k = 0; k <= n && k < rd_log.size(); k++)
      check({tag, "_re_addr"}, 32'(rd_log[k]), bus_addr(addr, k));
    for (int k = 0; k < n; k++)
      check({tag, "_rd_data"}, 32'(rx_words[k]), 32'(mem[bus_addr(addr, k)]));
    check({tag, "_we_count"}, wr_log.size(), 0);
    check({tag, "_word_cnt"}, 32'(word_cnt), n);
    check({tag, "_frame_done"}, fdone_cnt, 1);
    check_deselect(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(MISO), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] r;
    logic [15:0] base;
    int          n;

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[15'h4001] = 16'h1234;
    mem[15'h4002] = 16'h5678;
    mem_rdata = 16'h0000;
    nRst = 1'b0; SCK = 1'b0; MOSI = 1'b0; nSS = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    nRst = 1'b1;
    repeat (5) @(negedge clk);

    // Write burst
    clear_logs();
    tx_words[0] = 16'h0011; tx_words[1] = 16'h0022; tx_words[2] = 16'h0033;
    do_frame(16'h8020, 16, 3, 16);
    check_write("wr_burst", 16'h8020, 3);

    // Read burst with two dummy words
    clear_logs();
    tx_words[0] = 16'h0000; tx_words[1] = 16'h0000;
    do_frame(16'h4001, 16, 2, 16);
    check_read("rd_burst", 16'h4001, 2);
    check("rd_burst_w0", 32'(rx_words[0]), 32'h1234);
    check("rd_burst_w1", 32'(rx_words[1]), 32'h5678);

    // nSS rise during the address word aborts silently
    clear_logs();
    do_frame(16'h8123, 5, 0, 16);
    check("addr_abort_we", wr_log.size(), 0);
    check("addr_abort_re", rd_log.size(), 0);
    check("addr_abort_done", fdone_cnt, 0);

    // Abort after 9 bits of the second data word, then a clean frame
    clear_logs();
    tx_words[0] = 16'($urandom); tx_words[1] = 16'($urandom);
    do_frame(16'h8100, 16, 2, 9);
    check_write("wr_abort", 16'h8100, 1);
    clear_logs();
    tx_words[0] = 16'h00AA;
    do_frame(16'h8000, 16, 1, 16);
    check_write("wr_after_abort", 16'h8000, 1);

    // Address wrap at the top of the bus
    clear_logs();
    tx_words[0] = 16'($urandom); tx_words[1] = 16'($urandom);
    do_frame(16'hFFFF, 16, 2, 16);
    check_write("wr_wrap", 16'hFFFF, 2);

    // Randomised write and read frames
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      n = $urandom_range(1, 4);
      base = 16'h8000 | 16'($urandom_range(0, 32767));
      for (int k = 0; k < n; k++) tx_words[k] = 16'($urandom);
      do_frame(base, 16, n, 16);
      check_write("rnd_wr", base, n);
      clear_logs();
      n = $urandom_range(1, 4);
      base = 16'h5000 + 16'($urandom_range(0, 4095));
      for (int k = 0; k < n; k++) tx_words[k] = 16'($urandom);
      do_frame(base, 16, n, 16);
      check_read("rnd_rd", base, n);
    end

    // Reset in the middle of a data word
    clear_logs();
    tx_words[0] = 16'($urandom);
    nSS = 1'b0;
    repeat (2*HALF) @(negedge clk);
    spi_word(16'h8050, 16, rx_addr);
    spi_word(tx_words[0], 16, r);
    spi_word(16'hFFFF, 7, r);
    check("pre_rst_word_cnt", 32'(word_cnt), 32'd1);
    #2 nRst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    clear_logs();
    spi_word(16'hFFFF, 9, r);
    spi_word(16'h8888, 16, r);
    repeat (HALF) @(negedge clk);
    nSS = 1'b1;
    repeat (4*HALF) @(negedge clk);
    check("post_rst_we", wr_log.size(), 0);
    check("post_rst_re", rd_log.size(), 0);
    check("post_rst_done", fdone_cnt, 0);
    check("post_rst_word_cnt", 32'(word_cnt), 32'd0);
    clear_logs();
    tx_words[0] = 16'($urandom);
    do_frame(16'h8060, 16, 1, 16);
    check_write("post_rst_frame", 16'h8060, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
